// File: rtl/add_round_key_nb.sv
// AddRoundKey engine: XORs one round key column-by-column into the state.
// Optional AES_ARK_LOCK_EN adds a working_key port and LOCK_KEY parameter.
module add_round_key_nb #(
`ifdef AES_ARK_LOCK_EN
  parameter logic [1:0] LOCK_KEY = 2'b01,
`endif
  parameter int NB          = 4,
  parameter int DW          = 32,
  parameter int SA_W        = 5,
  parameter int WA_W        = 9,
  parameter int WORD_STRIDE = 120,
  parameter int N_W         = 5
) (
  input  logic            ap_clk,
  input  logic            ap_rst_n,
`ifdef AES_ARK_LOCK_EN
  input  logic [1:0]      working_key,
`endif
  input  logic            ap_start,
  output logic            ap_done,
  output logic            ap_idle,
  output logic            ap_ready,
  output logic            ap_err,
  input  logic [N_W-1:0]  n,
  output logic [SA_W-1:0] statemt_address0,
  output logic            statemt_ce0,
  output logic            statemt_we0,
  output logic [DW-1:0]   statemt_d0,
  input  logic [DW-1:0]   statemt_q0,
  output logic [SA_W-1:0] statemt_address1,
  output logic            statemt_ce1,
  output logic            statemt_we1,
  output logic [DW-1:0]   statemt_d1,
  input  logic [DW-1:0]   statemt_q1,
  output logic [WA_W-1:0] word_address0,
  output logic            word_ce0,
  input  logic [DW-1:0]   word_q0,
  output logic [WA_W-1:0] word_address1,
  output logic            word_ce1,
  input  logic [DW-1:0]   word_q1
);

  localparam int JW = $clog2(NB + 1);
  localparam logic [31:0] STR = 32'(WORD_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_RD01, S_RD23, S_WR01, S_WR23
  } state_t;

  state_t           state_q, state_d;
  logic [N_W-1:0]   n_q, n_d;
  logic [JW-1:0]    j_q, j_d;
  logic [DW-1:0]    d0_q, d0_d, d1_q, d1_d;

  logic [31:0]      nnb;
  logic [31:0]      kb;
  logic             oor;
  logic [SA_W-1:0]  sa;

  assign nnb = 32'(n_q) * 32'(NB);
  assign kb  = nnb + 32'(j_q);
  // n*NB+NB is the end of this round's key slice in every key row
  assign oor = (nnb + 32'(NB)) > STR;
  assign sa  = SA_W'(32'(j_q) * 32'd4);

  assign statemt_d0 = d0_q;
  assign statemt_d1 = d1_q;
  assign ap_ready   = ap_done;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      j_q     <= '0;
      d0_q    <= '0;
      d1_q    <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      j_q     <= j_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    n_d              = n_q;
    j_d              = j_q;
    d0_d             = d0_q;
    d1_d             = d1_q;
    ap_idle          = 1'b0;
    ap_done          = 1'b0;
    ap_err           = 1'b0;
    statemt_address0 = '0;
    statemt_address1 = '0;
    statemt_ce0      = 1'b0;
    statemt_ce1      = 1'b0;
    statemt_we0      = 1'b0;
    statemt_we1      = 1'b0;
    word_address0    = '0;
    word_address1    = '0;
    word_ce0         = 1'b0;
    word_ce1         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          n_d     = n;
          j_d     = '0;
          state_d = S_CHK;
`ifdef AES_ARK_LOCK_EN
          if (working_key[0] != LOCK_KEY[0]) state_d = S_WR01;
`endif
        end
      end
      S_CHK: begin
        if (oor) begin
          ap_done = 1'b1;
          ap_err  = 1'b1;
          state_d = S_IDLE;
        end else if (j_q == JW'(NB)) begin
`ifdef AES_ARK_LOCK_EN
          if (working_key[1] != LOCK_KEY[1]) begin
            state_d = S_WR01;
          end else begin
            ap_done = 1'b1;
            state_d = S_IDLE;
          end
`else
          ap_done = 1'b1;
          state_d = S_IDLE;
`endif
        end else begin
          state_d = S_RD01;
        end
      end
      S_RD01: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_address0 = sa;
        statemt_address1 = sa + SA_W'(1);
        word_ce0         = 1'b1;
        word_ce1         = 1'b1;
        word_address0    = WA_W'(kb);
        word_address1    = WA_W'(kb + STR);
        state_d          = S_RD23;
      end
      S_RD23: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_address0 = sa + SA_W'(2);
        statemt_address1 = sa + SA_W'(3);
        word_ce0         = 1'b1;
        word_ce1         = 1'b1;
        word_address0    = WA_W'(kb + 2 * STR);
        word_address1    = WA_W'(kb + 3 * STR);
        d0_d             = statemt_q0 ^ word_q0;
        d1_d             = statemt_q1 ^ word_q1;
        state_d          = S_WR01;
      end
      S_WR01: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = sa;
        statemt_address1 = sa + SA_W'(1);
        d0_d             = statemt_q0 ^ word_q0;
        d1_d             = statemt_q1 ^ word_q1;
        state_d          = S_WR23;
      end
      S_WR23: begin
        statemt_ce0      = 1'b1;
        statemt_ce1      = 1'b1;
        statemt_we0      = 1'b1;
        statemt_we1      = 1'b1;
        statemt_address0 = sa + SA_W'(2);
        statemt_address1 = sa + SA_W'(3);
        if (j_q != JW'(NB)) j_d = j_q + JW'(1);
        state_d          = S_CHK;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_add_round_key_nb.sv
// Bench for add_round_key_nb: NB=4 and NB=8 instances with memory models.
// Expected results are queued at start and checked at ap_done.
module tb_add_round_key_nb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_st, a_done, a_idle, a_rdy, a_err;
  logic [4:0]  a_n, a_sa0, a_sa1;
  logic        a_sce0, a_sce1, a_swe0, a_swe1, a_wce0, a_wce1;
  logic [31:0] a_sd0, a_sd1, a_sq0, a_sq1, a_wq0, a_wq1;
  logic [8:0]  a_wa0, a_wa1;

  logic        b_st, b_done, b_idle, b_rdy, b_err;
  logic [4:0]  b_n, b_sa0, b_sa1;
  logic        b_sce0, b_sce1, b_swe0, b_swe1, b_wce0, b_wce1;
  logic [31:0] b_sd0, b_sd1, b_sq0, b_sq1, b_wq0, b_wq1;
  logic [8:0]  b_wa0, b_wa1;

  add_round_key_nb #(.NB(4)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(a_st),
    .ap_done(a_done), .ap_idle(a_idle), .ap_ready(a_rdy),
    .ap_err(a_err), .n(a_n),
    .statemt_address0(a_sa0), .statemt_ce0(a_sce0),
    .statemt_we0(a_swe0), .statemt_d0(a_sd0), .statemt_q0(a_sq0),
    .statemt_address1(a_sa1), .statemt_ce1(a_sce1),
    .statemt_we1(a_swe1), .statemt_d1(a_sd1), .statemt_q1(a_sq1),
    .word_address0(a_wa0), .word_ce0(a_wce0), .word_q0(a_wq0),
    .word_address1(a_wa1), .word_ce1(a_wce1), .word_q1(a_wq1)
  );

  add_round_key_nb #(.NB(8)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(b_st),
    .ap_done(b_done), .ap_idle(b_idle), .ap_ready(b_rdy),
    .ap_err(b_err), .n(b_n),
    .statemt_address0(b_sa0), .statemt_ce0(b_sce0),
    .statemt_we0(b_swe0), .statemt_d0(b_sd0), .statemt_q0(b_sq0),
    .statemt_address1(b_sa1), .statemt_ce1(b_sce1),
    .statemt_we1(b_swe1), .statemt_d1(b_sd1), .statemt_q1(b_sq1),
    .word_address0(b_wa0), .word_ce0(b_wce0), .word_q0(b_wq0),
    .word_address1(b_wa1), .word_ce1(b_wce1), .word_q1(b_wq1)
  );

  logic [31:0] am [32];
  logic [31:0] bm [32];
  logic [31:0] ae [32];
  logic [31:0] be [32];
  logic        a_fill, b_fill;
  int          a_cecnt = 0;

  always @(posedge clk) begin
    if (a_fill) begin
      for (int i = 0; i < 32; i++) am[i] <= 32'(i);
    end else begin
      if (a_sce0) a_sq0 <= am[a_sa0];
      if (a_sce1) a_sq1 <= am[a_sa1];
      if (a_swe0) am[a_sa0] <= a_sd0;
      if (a_swe1) am[a_sa1] <= a_sd1;
    end
    if (a_wce0) a_wq0 <= 32'(a_wa0) << 8;
    if (a_wce1) a_wq1 <= 32'(a_wa1) << 8;
    a_cecnt <= a_cecnt + int'(a_sce0 | a_sce1 | a_wce0 | a_wce1);
  end

  always @(posedge clk) begin
    if (b_fill) begin
      for (int i = 0; i < 32; i++) bm[i] <= 32'(i);
    end else begin
      if (b_sce0) b_sq0 <= bm[b_sa0];
      if (b_sce1) b_sq1 <= bm[b_sa1];
      if (b_swe0) bm[b_sa0] <= b_sd0;
      if (b_swe1) bm[b_sa1] <= b_sd1;
    end
    if (b_wce0) b_wq0 <= 32'(b_wa0) << 8;
    if (b_wce1) b_wq1 <= 32'(b_wa1) << 8;
  end

  typedef struct {
    int cyc;
    bit err;
  } sb_t;

  sb_t sbq[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] key(input int r, input int nn,
                                      input int nb, input int j);
    return 32'((r * 120 + nn * nb + j) % 512) << 8;
  endfunction

  task automatic a_model(input int nn, input int dc);
    sb_t e;
    if (nn * 4 + 4 > 120) begin
      e.cyc = 1;
      e.err = 1'b1;
    end else begin
      e.cyc = dc;
      e.err = 1'b0;
      for (int j = 0; j < 4; j++)
        for (int r = 0; r < 4; r++)
          ae[4*j+r] = ae[4*j+r] ^ key(r, nn, 4, j);
    end
    sbq.push_back(e);
  endtask

  task automatic a_clear();
    a_fill = 1'b1;
    tick();
    a_fill = 1'b0;
    for (int i = 0; i < 32; i++) ae[i] = 32'(i);
  endtask

  task automatic a_wait();
    while (!a_done && cyc < 300) tick();
  endtask

  task automatic a_check(input string tag);
    sb_t e;
    if (sbq.size() == 0) begin
      e.cyc = -1;
      e.err = 1'b0;
    end else begin
      e = sbq.pop_front();
    end
    chk({tag, "_done_cyc"}, 32'(cyc), 32'(e.cyc));
    chk({tag, "_err"}, 32'(a_err), 32'(e.err));
    chk({tag, "_ready"}, 32'(a_rdy), 32'(a_done));
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_st%0d", tag, i), am[i], ae[i]);
  endtask

  initial begin
    int k;
    sb_t e;
    rst_n = 1'b0;
    a_st = 1'b0;
    b_st = 1'b0;
    a_n = '0;
    b_n = '0;
    a_fill = 1'b0;
    b_fill = 1'b0;
    tick();
    tick();
    chk("rst_idle", 32'(a_idle), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_ce", 32'({a_sce0, a_sce1, a_wce0, a_wce1}), 32'd0);
    chk("rst_we", 32'({a_swe0, a_swe1}), 32'd0);
    chk("rst_addr", 32'({a_sa0, a_sa1, a_wa0, a_wa1}), 32'd0);
    chk("rst_data", a_sd0 | a_sd1, 32'd0);
    rst_n = 1'b1;
    b_fill = 1'b1;
    a_clear();
    b_fill = 1'b0;

    a_model(3, 21);
    a_n = 5'd3;
    a_st = 1'b1;
    cyc = 0;
    tick();
    a_st = 1'b0;
    chk("busy", 32'(a_idle), 32'd0);
    a_wait();
    a_check("n3");
    tick();
    chk("done_pulse", 32'(a_done), 32'd0);
    chk("idle_after", 32'(a_idle), 32'd1);

    a_model(29, 21);
    a_n = 5'd29;
    a_st = 1'b1;
    cyc = 0;
    tick();
    a_st = 1'b0;
    a_wait();
    a_check("n29");
    tick();

    k = a_cecnt;
    a_model(30, 1);
    a_n = 5'd30;
    a_st = 1'b1;
    cyc = 0;
    tick();
    a_st = 1'b0;
    a_wait();
    a_check("n30");
    tick();
    tick();
    chk("err_no_ce", 32'(a_cecnt - k), 32'd0);
    chk("err_idle", 32'(a_idle), 32'd1);

    a_clear();
    a_n = 5'd3;
    a_st = 1'b1;
    cyc = 0;
    tick();
    a_st = 1'b0;
    while (cyc < 14) tick();
    chk("wr01_we", 32'({a_swe0, a_swe1}), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_idle", 32'(a_idle), 32'd1);
    chk("mid_rst_ce", 32'({a_sce0, a_sce1, a_wce0, a_wce1}), 32'd0);
    chk("mid_rst_we", 32'({a_swe0, a_swe1}), 32'd0);
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 4; r++)
        if (j < 2 || r < 2) ae[4*j+r] = ae[4*j+r] ^ key(r, 3, 4, j);
    for (int i = 0; i < 16; i++)
      chk($sformatf("mid_rst_st%0d", i), am[i], ae[i]);

    a_clear();
    a_n = 5'd3;
    a_st = 1'b1;
    cyc = 0;
    tick();
    for (int r = 1; r <= 3; r++) begin
      a_model(3, 21 + 22 * (r - 1));
      a_wait();
      if (r == 3) a_st = 1'b0;
      a_check($sformatf("b2b%0d", r));
      tick();
      chk($sformatf("b2b_idle%0d", r), 32'(a_idle), 32'd1);
    end
    tick();
    chk("b2b_stay_idle", 32'(a_idle), 32'd1);

    for (int i = 0; i < 32; i++) be[i] = 32'(i);
    for (int j = 0; j < 8; j++)
      for (int r = 0; r < 4; r++)
        be[4*j+r] = be[4*j+r] ^ key(r, 2, 8, j);
    e.cyc = 41;
    e.err = 1'b0;
    sbq.push_back(e);
    b_n = 5'd2;
    b_st = 1'b1;
    cyc = 0;
    tick();
    b_st = 1'b0;
    while (!b_done && cyc < 300) tick();
    e = sbq.pop_front();
    chk("nb8_done_cyc", 32'(cyc), 32'(e.cyc));
    chk("nb8_err", 32'(b_err), 32'(e.err));
    chk("nb8_ready", 32'(b_rdy), 32'd1);
    for (int i = 0; i < 32; i++)
      chk($sformatf("nb8_st%0d", i), bm[i], be[i]);
    tick();
    chk("nb8_idle", 32'(b_idle), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
